// File: rtl/pipe_stage_exmem.sv
// pipe_stage_exmem: EX/MEM pipeline register with optional two-entry skid buffer and valid/ready handshakes.
module pipe_stage_exmem #(
  parameter int XLEN = 64,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] rs2_val_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic [4:0]      rd_idx_in,
  input  logic [2:0]      funct3_in,
  input  logic [1:0]      mem_to_reg_in,
  input  logic            reg_write_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] rs2_val_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic [4:0]      rd_idx_out,
  output logic [2:0]      funct3_out,
  output logic [1:0]      mem_to_reg_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic [1:0]      occupancy,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd
);
  localparam int PW = 3*XLEN + 13;
  logic [PW-1:0] in_p, head_q, head_d, skid_q, skid_d;
  logic          head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic          acc, xfer;
  logic [2:0]    ctl;
  assign in_p = {alu_result_in, rs2_val_in, pc_plus4_in, rd_idx_in, funct3_in, mem_to_reg_in,
                 reg_write_in, mem_read_in, mem_write_in};
  assign in_ready = (SKID != 0) ? !skid_v_q : (out_ready || !head_v_q);
  assign acc      = in_valid && in_ready;
  assign xfer     = head_v_q && out_ready;
  // The skid entry only fills when the head is full and stalled; without SKID that accept is impossible.
  always_comb begin
    head_d   = head_q;
    skid_d   = skid_q;
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!head_v_q || xfer) begin
      head_v_d = skid_v_q || acc;
      head_d   = skid_v_q ? skid_q : (acc ? in_p : head_q);
      skid_v_d = 1'b0;
    end else if (acc) begin
      skid_v_d = 1'b1;
      skid_d   = in_p;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      skid_q   <= skid_d;
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
    end
  end
  assign {alu_result_out, rs2_val_out, pc_plus4_out, rd_idx_out, funct3_out, mem_to_reg_out, ctl} = head_q;
  assign out_valid     = head_v_q;
  assign reg_write_out = ctl[2] && head_v_q;
  assign mem_read_out  = ctl[1] && head_v_q;
  assign mem_write_out = ctl[0] && head_v_q;
  assign occupancy     = {1'b0, head_v_q} + {1'b0, skid_v_q};
  assign fwd_valid     = head_v_q && ctl[2] && (rd_idx_out != 5'd0);
  assign fwd_rd        = rd_idx_out;
endmodule

// File: tb/tb_pipe_stage_exmem.sv
// tb_pipe_stage_exmem: random and directed traffic into SKID=1 and SKID=0 instances, checked against FIFO models.
module tb_pipe_stage_exmem;
  localparam int XL = 64;
  localparam int PW = 3*XL + 13;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [PW-1:0] pin = '0;
  wire  [PW-1:0] po1, po0;
  wire  in_ready1, in_ready0, ov1, ov0, fv1, fv0;
  wire  [1:0] occ1, occ0;
  wire  [4:0] fr1, fr0;
  int checks = 0, errors = 0;
  logic [PW-1:0] q1[$], q0[$];
  logic [PW-1:0] last1 = '0, last0 = '0;

  always #5 clk = ~clk;

  pipe_stage_exmem #(.XLEN(XL), .SKID(1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .out_valid(ov1), .out_ready(out_ready),
    .alu_result_in(pin[204:141]), .rs2_val_in(pin[140:77]), .pc_plus4_in(pin[76:13]),
    .rd_idx_in(pin[12:8]), .funct3_in(pin[7:5]), .mem_to_reg_in(pin[4:3]),
    .reg_write_in(pin[2]), .mem_read_in(pin[1]), .mem_write_in(pin[0]),
    .alu_result_out(po1[204:141]), .rs2_val_out(po1[140:77]), .pc_plus4_out(po1[76:13]),
    .rd_idx_out(po1[12:8]), .funct3_out(po1[7:5]), .mem_to_reg_out(po1[4:3]),
    .reg_write_out(po1[2]), .mem_read_out(po1[1]), .mem_write_out(po1[0]),
    .occupancy(occ1), .fwd_valid(fv1), .fwd_rd(fr1));

  pipe_stage_exmem #(.XLEN(XL), .SKID(0)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .out_valid(ov0), .out_ready(out_ready),
    .alu_result_in(pin[204:141]), .rs2_val_in(pin[140:77]), .pc_plus4_in(pin[76:13]),
    .rd_idx_in(pin[12:8]), .funct3_in(pin[7:5]), .mem_to_reg_in(pin[4:3]),
    .reg_write_in(pin[2]), .mem_read_in(pin[1]), .mem_write_in(pin[0]),
    .alu_result_out(po0[204:141]), .rs2_val_out(po0[140:77]), .pc_plus4_out(po0[76:13]),
    .rd_idx_out(po0[12:8]), .funct3_out(po0[7:5]), .mem_to_reg_out(po0[4:3]),
    .reg_write_out(po0[2]), .mem_read_out(po0[1]), .mem_write_out(po0[0]),
    .occupancy(occ0), .fwd_valid(fv0), .fwd_rd(fr0));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected view of a stage holding sz entries with head h: control bits gated by valid, data held when empty.
  task automatic chk_out(input string n, input logic [PW-1:0] got, input logic ov, input logic [1:0] occ,
                         input logic fv, input logic [4:0] fr, input logic [PW-1:0] h, input int sz);
    chk({n, "_out_valid"}, 256'(ov), 256'(sz > 0));
    chk({n, "_occupancy"}, 256'(occ), 256'(sz));
    chk({n, "_payload"}, 256'(got), 256'({h[PW-1:3], h[2:0] & {3{sz > 0}}}));
    chk({n, "_fwd_valid"}, 256'(fv), 256'(sz > 0 && h[2] && h[12:8] != 5'd0));
    chk({n, "_fwd_rd"}, 256'(fr), 256'(h[12:8]));
  endtask

  task automatic check_all();
    if (q1.size() > 0) last1 = q1[0];
    if (q0.size() > 0) last0 = q0[0];
    chk_out("s1", po1, ov1, occ1, fv1, fr1, last1, q1.size());
    chk_out("s0", po0, ov0, occ0, fv0, fr0, last0, q0.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    #1;
    q1.delete();
    q0.delete();
    last1 = '0;
    last0 = '0;
    check_all();
    chk("s1_in_ready_rst", 256'(in_ready1), 256'(1));
    chk("s0_in_ready_rst", 256'(in_ready0), 256'(1));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic iv, input logic [PW-1:0] p, input logic ordy, input logic fl);
    logic acc1, acc0, pop1, pop0;
    @(negedge clk);
    check_all();
    in_valid = iv;
    pin = p;
    out_ready = ordy;
    flush = fl;
    #1;
    chk("s1_in_ready", 256'(in_ready1), 256'(q1.size() < 2));
    chk("s0_in_ready", 256'(in_ready0), 256'(ordy || q0.size() == 0));
    acc1 = iv && q1.size() < 2;
    acc0 = iv && (ordy || q0.size() == 0);
    pop1 = ordy && q1.size() > 0;
    pop0 = ordy && q0.size() > 0;
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (pop1) void'(q1.pop_front());
      if (acc1) q1.push_back(p);
      if (pop0) void'(q0.pop_front());
      if (acc0) q0.push_back(p);
    end
  endtask

  function automatic logic [PW-1:0] rnd_p();
    logic [PW-1:0] p;
    p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 13'($urandom_range(0, 8191))};
    if ($urandom_range(0, 3) == 0) p[12:8] = 5'd0;
    return p;
  endfunction

  function automatic logic [PW-1:0] mk(input logic [63:0] alu, input logic [4:0] rd, input logic [2:0] ctl);
    return {alu, 64'h0, 64'h0, rd, 3'd3, 2'd1, ctl};
  endfunction

  initial begin
    do_reset();
    step(1'b1, mk(64'h1234, 5'd5, 3'b100), 1'b1, 1'b0);
    step(1'b0, mk(64'hdead, 5'd7, 3'b111), 1'b1, 1'b0);
    step(1'b1, mk(64'h0a, 5'd0, 3'b100), 1'b1, 1'b0);
    step(1'b1, mk(64'h0b, 5'd9, 3'b001), 1'b1, 1'b0);
    step(1'b0, mk(64'h0c, 5'd1, 3'b111), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, mk(64'hA, 5'd1, 3'b100), 1'b0, 1'b0);
    step(1'b1, mk(64'hB, 5'd2, 3'b100), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, mk(64'hA, 5'd1, 3'b001), 1'b0, 1'b0);
    step(1'b1, mk(64'hB, 5'd2, 3'b001), 1'b0, 1'b0);
    step(1'b1, mk(64'hC, 5'd3, 3'b001), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, mk(64'hD, 5'd4, 3'b100), 1'b0, 1'b0);
    do_reset();
    step(1'b1, mk(64'hE, 5'd6, 3'b100), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 9) < 7, rnd_p(), $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
